// File: rtl/timer_sequencer.sv
// timer_sequencer: on an upstream request, drives a companion N-cycle START/READY/RESET timer a programmed number of times.
// Optional WAIT-state watchdog is built when TIMER_SEQUENCER_WATCHDOG_EN is defined.
module timer_sequencer #(
  parameter int N        = 8,
  parameter int WD_LIMIT = 2 * N
) (
  input  logic       CLK,
  input  logic       N_RESET,
  input  logic       REQ,
  input  logic [7:0] REPEATS,
  output logic       START,
  output logic       RESET,
  input  logic       READY,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] COUNT,
  output logic [2:0] fsm_state
);

  // Handshake: START and RESET are one-cycle Moore pulses toward the timer (RESET held only in FAULT);
  // READY is a level sampled only in WAIT, and REQ=0 in WAIT wins over READY.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_WAIT  = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] remaining;

  if (N < 3 || WD_LIMIT < N) begin : g_param_check
    $error("timer_sequencer: requires N >= 3 and WD_LIMIT >= N");
  end

`ifdef TIMER_SEQUENCER_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd;

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      wd <= '0;
    end else if (state == S_ARM) begin
      wd <= '0;
    end else if (state == S_WAIT && REQ && !READY && wd != WD_W'(WD_LIMIT)) begin
      wd <= wd + WD_W'(1);
    end
  end
`endif

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (REQ) next_state = (REPEATS != 8'd0) ? S_ARM : S_DONE;
      end
      S_ARM: next_state = REQ ? S_WAIT : S_ABORT;
      S_WAIT: begin
        if (!REQ) next_state = S_ABORT;
        else if (READY) next_state = S_CLEAR;
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
        else if (wd == WD_W'(WD_LIMIT - 1)) next_state = S_FAULT;
`endif
      end
      // The timer is cleared in this cycle, so a dropped request needs no extra ABORT pulse.
      S_CLEAR: begin
        if (!REQ) next_state = S_IDLE;
        else if (remaining == 8'd1) next_state = S_DONE;
        else next_state = S_ARM;
      end
      S_DONE:  if (!REQ) next_state = S_IDLE;
      S_ABORT: next_state = S_IDLE;
      S_FAULT: if (!REQ) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      remaining <= 8'd0;
      COUNT     <= 8'd0;
    end else if (state == S_IDLE && REQ) begin
      remaining <= REPEATS;
      COUNT     <= 8'd0;
    end else if (state == S_CLEAR) begin
      remaining <= remaining - 8'd1;
      COUNT     <= COUNT + 8'd1;
    end
  end

  always_comb begin
    START = 1'b0;
    RESET = 1'b0;
    BUSY  = 1'b0;
    DONE  = 1'b0;
    ERR   = 1'b0;
    case (state)
      S_ARM: begin
        START = 1'b1;
        BUSY  = 1'b1;
      end
      S_WAIT: BUSY = 1'b1;
      S_CLEAR, S_ABORT: begin
        RESET = 1'b1;
        BUSY  = 1'b1;
      end
      S_DONE: DONE = 1'b1;
      S_FAULT: begin
        RESET = 1'b1;
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
        ERR   = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: pairs timer_sequencer with an N=8 companion timer model and checks pulse timing, counts and status.
module tb_timer_sequencer;
  localparam int N        = 8;
  localparam int WD_LIMIT = 16;
  localparam int W        = 16;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [3:0] TMR_LAST = 4'(N - 1);

  logic       CLK = 1'b0;
  logic       N_RESET = 1'b0;
  logic       REQ = 1'b0;
  logic [7:0] REPEATS = 8'd0;
  logic       READY;
  logic       START, RESET, BUSY, DONE, ERR;
  logic [7:0] COUNT;
  logic [2:0] fsm_state;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] cyc = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rst_q[$];
  logic [W-1:0] mon_exp;
  logic force_ready_low = 1'b0;
  logic start_d = 1'b0;
  logic rst_d = 1'b0;
  logic [3:0] tmr_cnt;

  timer_sequencer #(.N(N), .WD_LIMIT(WD_LIMIT)) dut (
    .CLK(CLK), .N_RESET(N_RESET), .REQ(REQ), .REPEATS(REPEATS),
    .START(START), .RESET(RESET), .READY(READY), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR), .COUNT(COUNT), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + W'(1);

  // companion timer: START -> state 1, counts to N-1 and holds READY until RESET
  always @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) tmr_cnt <= 4'd0;
    else if (RESET) tmr_cnt <= 4'd0;
    else if (START) tmr_cnt <= 4'd1;
    else if (tmr_cnt != 4'd0 && tmr_cnt != TMR_LAST) tmr_cnt <= tmr_cnt + 4'd1;
  end
  assign READY = (tmr_cnt == TMR_LAST) && !force_ready_low;

  // scoreboard: rising START/RESET edges popped against expected cycle numbers
  always @(negedge CLK) begin
    vectors++;
    if (START === 1'b1 && RESET === 1'b1) begin
      miscompares++; $display("FAIL start_reset_overlap: both high at cycle %0d", cyc);
    end
    if (DONE === 1'b1 && ERR === 1'b1) begin
      miscompares++; $display("FAIL done_err_overlap: both high at cycle %0d", cyc);
    end
    if (START === 1'b1 && fsm_state !== ST_ARM) begin
      miscompares++; $display("FAIL start_state: START in state %0d, required %0d", fsm_state, ST_ARM);
    end
    if (START === 1'b1 && !start_d) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++; $display("FAIL start_pulse: unexpected at cycle %0d", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cyc !== mon_exp) begin
          miscompares++; $display("FAIL start_pulse: cycle %0d, required %0d", cyc, mon_exp);
        end
      end
    end
    if (RESET === 1'b1 && !rst_d) begin
      vectors++;
      if (exp_rst_q.size() == 0) begin
        miscompares++; $display("FAIL reset_pulse: unexpected at cycle %0d", cyc);
      end else begin
        mon_exp = exp_rst_q.pop_front();
        if (cyc !== mon_exp) begin
          miscompares++; $display("FAIL reset_pulse: cycle %0d, required %0d", cyc, mon_exp);
        end
      end
    end
    start_d = START;
    rst_d   = RESET;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // driver: raise REQ and queue the pulse times of `runs` complete timer runs
  task automatic drive_request(input logic [7:0] reps, input int runs, output logic [W-1:0] c0);
    REQ = 1'b1;
    REPEATS = reps;
    c0 = cyc + W'(1);
    for (int i = 0; i < runs; i++) begin
      exp_q.push_back(c0 + W'((N + 1) * i));
      exp_rst_q.push_back(c0 + W'((N + 1) * i + N));
    end
  endtask

  task automatic wait_done(input int budget, output logic timed_out, output logic [W-1:0] done_cyc);
    timed_out = 1'b1;
    done_cyc = '0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (DONE === 1'b1) begin
        timed_out = 1'b0;
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    N_RESET = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({START, RESET, BUSY, DONE, ERR} !== 5'b0 || COUNT !== 8'd0 || fsm_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_outputs: flags %b count %0d state %0d, required 00000 0 0",
               {START, RESET, BUSY, DONE, ERR}, COUNT, fsm_state);
    end
    N_RESET = 1'b1;
    repeat (2) tick();
    vectors++;
    if (fsm_state !== ST_IDLE || BUSY !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle: state %0d busy %b, required 0 0", fsm_state, BUSY);
    end
  endtask

  task automatic test_three_runs();
    logic [W-1:0] c0, dc;
    logic to;
    drive_request(8'd3, 3, c0);
    wait_done(60, to, dc);
    vectors++;
    if (to || dc !== c0 + W'(27)) begin
      miscompares++; $display("FAIL three_done_cycle: got %0d (timeout %b), required %0d", dc, to, c0 + W'(27));
    end
    vectors++;
    if (COUNT !== 8'd3) begin
      miscompares++; $display("FAIL three_count: got %0d, required 3", COUNT);
    end
    vectors++;
    if (exp_q.size() != 0 || exp_rst_q.size() != 0) begin
      miscompares++; $display("FAIL three_pulses: %0d START and %0d RESET pulses missing", exp_q.size(), exp_rst_q.size());
    end
    REQ = 1'b0;
    tick();
    vectors++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || fsm_state !== ST_IDLE || COUNT !== 8'd3) begin
      miscompares++; $display("FAIL three_release: done %b state %0d count %0d, required 0 0 3", DONE, fsm_state, COUNT);
    end
  endtask

  task automatic test_zero_repeats();
    logic [W-1:0] c0;
    drive_request(8'd0, 0, c0);
    tick();
    vectors++;
    if (DONE !== 1'b1 || cyc !== c0 || COUNT !== 8'd0 || BUSY !== 1'b0) begin
      miscompares++; $display("FAIL zero_done: done %b cycle %0d count %0d busy %b, required 1 %0d 0 0", DONE, cyc, COUNT, BUSY, c0);
    end
    repeat (3) tick();
    vectors++;
    if (DONE !== 1'b1) begin
      miscompares++; $display("FAIL zero_hold: done %b, required 1", DONE);
    end
    REQ = 1'b0;
    tick();
    vectors++;
    if (DONE !== 1'b0 || fsm_state !== ST_IDLE) begin
      miscompares++; $display("FAIL zero_release: done %b state %0d, required 0 0", DONE, fsm_state);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] c0;
    logic done_seen;
    done_seen = 1'b0;
    drive_request(8'd5, 1, c0);
    exp_q.push_back(c0 + W'(N + 1));
    for (int i = 0; i < 12; i++) begin
      tick();
      done_seen |= DONE;
    end
    vectors++;
    if (fsm_state !== ST_WAIT) begin
      miscompares++; $display("FAIL abort_in_wait: state %0d, required %0d", fsm_state, ST_WAIT);
    end
    REQ = 1'b0;
    exp_rst_q.push_back(cyc + W'(1));
    tick();
    done_seen |= DONE;
    vectors++;
    if (RESET !== 1'b1 || BUSY !== 1'b1) begin
      miscompares++; $display("FAIL abort_pulse: reset %b busy %b, required 1 1", RESET, BUSY);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      done_seen |= DONE;
    end
    vectors++;
    if (fsm_state !== ST_IDLE || COUNT !== 8'd1 || done_seen !== 1'b0) begin
      miscompares++; $display("FAIL abort_end: state %0d count %0d done_seen %b, required 0 1 0", fsm_state, COUNT, done_seen);
    end
    vectors++;
    if (exp_q.size() != 0 || exp_rst_q.size() != 0) begin
      miscompares++; $display("FAIL abort_pulses: %0d START and %0d RESET pulses missing", exp_q.size(), exp_rst_q.size());
    end
  endtask

  task automatic test_watchdog();
    logic [W-1:0] c0;
    logic bad;
    force_ready_low = 1'b1;
    drive_request(8'd1, 0, c0);
    exp_q.push_back(c0);
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
    exp_rst_q.push_back(c0 + W'(WD_LIMIT + 1));
    repeat (WD_LIMIT + 1) tick();
    vectors++;
    if (ERR !== 1'b0 || fsm_state !== ST_WAIT) begin
      miscompares++; $display("FAIL wd_before: err %b state %0d, required 0 %0d", ERR, fsm_state, ST_WAIT);
    end
    tick();
    vectors++;
    if (ERR !== 1'b1 || RESET !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      miscompares++; $display("FAIL wd_fault: err %b reset %b done %b busy %b, required 1 1 0 0", ERR, RESET, DONE, BUSY);
    end
    repeat (3) tick();
    vectors++;
    if (ERR !== 1'b1 || RESET !== 1'b1) begin
      miscompares++; $display("FAIL wd_hold: err %b reset %b, required 1 1", ERR, RESET);
    end
    REQ = 1'b0;
    tick();
`else
    bad = 1'b0;
    for (int i = 0; i < 101; i++) begin
      tick();
      if (i > 0 && (ERR !== 1'b0 || fsm_state !== ST_WAIT)) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++; $display("FAIL wd_absent: left WAIT or raised ERR, err %b state %0d", ERR, fsm_state);
    end
    REQ = 1'b0;
    exp_rst_q.push_back(cyc + W'(1));
    tick();
    vectors++;
    if (RESET !== 1'b1) begin
      miscompares++; $display("FAIL wd_abort: reset %b, required 1", RESET);
    end
    tick();
`endif
    vectors++;
    if (ERR !== 1'b0 || fsm_state !== ST_IDLE || RESET !== 1'b0) begin
      miscompares++; $display("FAIL wd_release: err %b state %0d reset %b, required 0 0 0", ERR, fsm_state, RESET);
    end
    force_ready_low = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [W-1:0] c0, dc;
    logic to;
    drive_request(8'd2, 1, c0);
    exp_q.push_back(c0 + W'(N + 1));
    repeat (13) tick();
    vectors++;
    if (COUNT !== 8'd1 || fsm_state !== ST_WAIT) begin
      miscompares++; $display("FAIL areset_pre: count %0d state %0d, required 1 %0d", COUNT, fsm_state, ST_WAIT);
    end
    #1 N_RESET = 1'b0;
    REQ = 1'b0;
    #1;
    vectors++;
    if ({START, RESET, BUSY, DONE, ERR} !== 5'b0 || COUNT !== 8'd0 || fsm_state !== ST_IDLE) begin
      miscompares++; $display("FAIL areset_async: flags %b count %0d state %0d, required 00000 0 0",
                              {START, RESET, BUSY, DONE, ERR}, COUNT, fsm_state);
    end
    tick();
    N_RESET = 1'b1;
    tick();
    drive_request(8'd1, 1, c0);
    wait_done(30, to, dc);
    vectors++;
    if (to || dc !== c0 + W'(N + 1) || COUNT !== 8'd1) begin
      miscompares++; $display("FAIL areset_rerun: done cycle %0d count %0d, required %0d 1", dc, COUNT, c0 + W'(N + 1));
    end
    REQ = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] c0, dc;
    logic [7:0] reps;
    logic to;
    drive_request(8'd255, 255, c0);
    wait_done(2400, to, dc);
    vectors++;
    if (to || dc !== c0 + W'(255 * (N + 1)) || COUNT !== 8'd255) begin
      miscompares++; $display("FAIL max_repeats: done cycle %0d count %0d, required %0d 255", dc, COUNT, c0 + W'(255 * (N + 1)));
    end
    REQ = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      reps = 8'($urandom_range(1, 12));
      drive_request(reps, int'(reps), c0);
      tick();
      REPEATS = 8'($urandom_range(0, 255));
      wait_done(150, to, dc);
      vectors++;
      if (to || dc !== c0 + W'(int'(reps) * (N + 1)) || COUNT !== reps) begin
        miscompares++; $display("FAIL random_run: reps %0d done cycle %0d count %0d, required %0d %0d",
                                reps, dc, COUNT, c0 + W'(int'(reps) * (N + 1)), reps);
      end
      REQ = 1'b0;
      tick();
    end
    vectors++;
    if (exp_q.size() != 0 || exp_rst_q.size() != 0) begin
      miscompares++; $display("FAIL b2b_pulses: %0d START and %0d RESET pulses missing", exp_q.size(), exp_rst_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_three_runs();
    test_zero_repeats();
    test_abort();
    test_watchdog();
    test_async_reset();
    test_back_to_back();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL global_timeout: simulation did not complete by time %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
